pixel_stream_capture: RTL and testbench
=======================================

# pixel_stream_capture

Parametrised, synthesizable frame-capture engine for the camera filter pipeline. It selects one of NUM_CH filter output streams (e.g. gray/Sobel/Canny), aligns to start-of-frame, captures exactly IMG_WIDTH*IMG_HEIGHT qualified pixels into a FIFO, and drains them over a valid/ready port to a debug/readout consumer (UART/SD/host bridge). It sits after the filter bank in the clk_25MHz pixel domain.

## Interface
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame
- PIX_W, 8, bits per pixel per channel
- NUM_CH, 4, number of filter channels (>=2)
- FIFO_DEPTH, 16, FIFO entries (power of two, >=2)
- clk_25MHz  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  arm request; honoured only in IDLE or DONE
- abort  in  1  return to IDLE from any state, flush FIFO
- ch_sel  in  $clog2(NUM_CH)  channel select, latched on accepted start
- sof  in  1  start-of-frame pulse, one cycle
- pix_data  in  NUM_CH*PIX_W  channel k at bits [k*PIX_W +: PIX_W]
- pix_valid  in  NUM_CH  per-channel pixel qualifier
- out_data  out  PIX_W  FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- busy  out  1  state is WAIT_SOF, CAPTURE or DRAIN
- done  out  1  state is DONE
- overflow  out  1  sticky: a pixel was dropped on full FIFO
- frame_err  out  1  sticky: sof arrived before frame completed
- px_count  out  $clog2(IMG_WIDTH*IMG_HEIGHT+1)  source pixels seen this capture

## Operation
- States: IDLE, WAIT_SOF, CAPTURE, DRAIN, DONE.
- IDLE/DONE --start--> WAIT_SOF: latch ch_sel; clear px_count, overflow, frame_err; flush FIFO.
- WAIT_SOF --sof--> CAPTURE. A pixel with pix_valid[sel] in the sof cycle is captured.
- CAPTURE: each cycle with pix_valid[sel]=1 increments px_count and pushes pix_data[sel]; other channels ignored.
- Push when FIFO not full, or full with a pop in the same cycle. Otherwise the pixel is dropped, overflow set, px_count still increments.
- CAPTURE -> DRAIN when px_count reaches IMG_WIDTH*IMG_HEIGHT (on the increment edge). The terminal pixel is pushed.
- sof in CAPTURE after the first capture cycle: set frame_err, go to DRAIN, no push from that cycle.
- DRAIN -> DONE when FIFO is empty. done holds until start or abort.
- abort wins over every other event the same cycle: next state IDLE, FIFO flushed; flags and px_count retained until next start.
- start outside IDLE/DONE is ignored.
- FIFO: circular pointers with wrap at FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, busy 0, done 0, overflow 0, frame_err 0, px_count 0, FIFO empty.
- A pixel pushed at edge N gives out_valid=1 after edge N (first-word latency 1 cycle). out_data is stable while out_valid && !out_ready.
- Pop at an edge advances the head; new head is visible the same cycle after that edge.
- busy, done and overflow are registered and change on the edge that changes the state or flag.
- Sustained capture at one pixel/cycle with out_ready=1 never overflows.

## Configuration
- CAPTURE_CHECKSUM_EN defined: adds output checksum [31:0]. It is cleared on accepted start. On every push it updates as checksum = {checksum[30:0],checksum[31]} ^ zero-extended pixel; it is held after DONE.
- Undefined: no checksum port and no checksum logic; all other behaviour is identical.

## Test plan
- W=4, H=2, DEPTH=4, ch_sel=2, out_ready=1: start, sof, 8 valid pixels 0x10..0x17 on ch2 with other channels at 0xFF -> out stream 0x10..0x17, done=1, px_count=8, overflow=0.
- Same setup, out_ready=0 during capture -> first 4 pixels kept. The next 4 pixels are dropped and overflow=1. After out_ready=1 -> 0x10..0x13 drained, done=1, px_count=8.
- sof after 3 pixels -> frame_err=1, DRAIN of 3 pixels, done=1, px_count=3.
- Full FIFO plus simultaneous pop and push -> no drop, occupancy stays 4, overflow=0.
- abort mid-CAPTURE with 2 entries in FIFO -> next cycle IDLE, out_valid=0, busy=0. rst_n low mid-DRAIN -> all outputs at reset values immediately.
- CAPTURE_CHECKSUM_EN defined, pixels 0x01,0x02 -> checksum 0x00000000 (0x01, then (0x01 rotated left)^0x02 = 0x02^0x02 = 0). Pixels 0x01,0x03 -> checksum 0x00000001.

Source files
------------

// File: rtl/pixel_stream_capture_if.sv
// Readout stream between the capture engine and its consumer.
//   out_data  : FIFO head pixel
//   out_valid : FIFO non-empty
//   out_ready : consumer accepts the head when out_valid && out_ready
// master = capture engine (producer), slave = readout consumer.
interface pixel_stream_capture_if #(
   parameter int unsigned PIX_W = 8
) ();
   logic [PIX_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/pixel_stream_capture.sv
// Frame-capture engine: selects one filter channel, aligns to start-of-frame,
// captures IMG_WIDTH*IMG_HEIGHT qualified pixels into a FIFO and drains them
// over a valid/ready readout stream.
// Ports:
//   clk_25MHz, rst_n : pixel clock, async active-low reset
//   start, abort     : arm request (IDLE/DONE only) / return to IDLE + flush
//   ch_sel           : channel select, latched on accepted start
//   sof              : start-of-frame pulse
//   pix_data         : NUM_CH packed pixels, channel k at [k*PIX_W +: PIX_W]
//   pix_valid        : per-channel pixel qualifier
//   out_if           : readout stream (out_data/out_valid/out_ready)
//   busy, done       : state is WAIT_SOF/CAPTURE/DRAIN, state is DONE
//   overflow         : sticky, a pixel was dropped on a full FIFO
//   frame_err        : sticky, sof arrived before the frame completed
//   px_count         : source pixels seen this capture
// Optional feature macro CAPTURE_CHECKSUM_EN adds the 32-bit rotate-xor
// checksum output over all pushed pixels.
module pixel_stream_capture #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter int unsigned PIX_W      = 8,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                                       clk_25MHz,
   input  logic                                       rst_n,
   input  logic                                       start,
   input  logic                                       abort,
   input  logic [$clog2(NUM_CH)-1:0]                  ch_sel,
   input  logic                                       sof,
   input  logic [NUM_CH*PIX_W-1:0]                    pix_data,
   input  logic [NUM_CH-1:0]                          pix_valid,
   pixel_stream_capture_if.master                     out_if,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       overflow,
   output logic                                       frame_err,
   output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0]  px_count
`ifdef CAPTURE_CHECKSUM_EN
   ,
   output logic [31:0]                                checksum
`endif
);

   localparam int unsigned TOTAL = IMG_WIDTH * IMG_HEIGHT;
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);
   localparam int unsigned CH_W  = $clog2(NUM_CH);
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned OW    = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_SOF, S_CAPTURE, S_DRAIN, S_DONE} state_t;

   state_t            state;
   logic [CH_W-1:0]   sel;
   logic [PIX_W-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [OW-1:0]     occ;

   logic [PIX_W-1:0]  sel_pix;
   logic              sel_valid;
   logic              pop, push, capture_pix, last_pix;
   logic [CNT_W-1:0]  px_next;
   logic [AW-1:0]     rd_next;
   logic [OW-1:0]     occ_next;
   logic [PIX_W-1:0]  head_next;

   // Channel mux, capture qualification and FIFO next-state terms.
   always_comb begin
      sel_pix   = '0;
      sel_valid = 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (sel == CH_W'(k)) begin
            sel_pix   = pix_data[k*PIX_W +: PIX_W];
            sel_valid = pix_valid[k];
         end
      end
      pop = out_if.out_valid && out_if.out_ready;
      // The sof cycle itself counts as the first capture cycle; a later sof aborts the frame.
      capture_pix = sel_valid &&
                    (((state == S_WAIT_SOF) && sof) || ((state == S_CAPTURE) && !sof));
      // A full FIFO still accepts a pixel when the head leaves on the same edge.
      push     = capture_pix && ((occ != OW'(FIFO_DEPTH)) || pop);
      px_next  = px_count + CNT_W'(1);
      last_pix = (px_next == CNT_W'(TOTAL));
      rd_next  = pop ? rd_ptr + AW'(1) : rd_ptr;
      occ_next = occ;
      if (push && !pop) begin
         occ_next = occ + OW'(1);
      end else if (pop && !push) begin
         occ_next = occ - OW'(1);
      end
      // Registered head: the pushed pixel bypasses memory when it lands on the new read slot.
      head_next = (push && (wr_ptr == rd_next)) ? sel_pix : mem[rd_next];
   end

   // Control FSM, flags and FIFO storage.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         sel              <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         occ              <= '0;
         out_if.out_valid <= 1'b0;
         out_if.out_data  <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         overflow         <= 1'b0;
         frame_err        <= 1'b0;
         px_count         <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
`ifdef CAPTURE_CHECKSUM_EN
         checksum         <= '0;
`endif
      end else if (abort) begin
         // Flags and px_count are kept for inspection until the next start.
         state            <= S_IDLE;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         occ              <= '0;
         out_if.out_valid <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= sel_pix;
            wr_ptr      <= wr_ptr + AW'(1);
`ifdef CAPTURE_CHECKSUM_EN
            checksum    <= {checksum[30:0], checksum[31]} ^ 32'(sel_pix);
`endif
         end
         rd_ptr           <= rd_next;
         occ              <= occ_next;
         out_if.out_valid <= (occ_next != '0);
         out_if.out_data  <= head_next;

         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state            <= S_WAIT_SOF;
                  sel              <= ch_sel;
                  px_count         <= '0;
                  overflow         <= 1'b0;
                  frame_err        <= 1'b0;
                  wr_ptr           <= '0;
                  rd_ptr           <= '0;
                  occ              <= '0;
                  out_if.out_valid <= 1'b0;
                  busy             <= 1'b1;
                  done             <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
                  checksum         <= '0;
`endif
               end
            end
            S_WAIT_SOF: begin
               if (sof) begin
                  state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (sof) begin
                  frame_err <= 1'b1;
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (occ == '0) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase

         // Counted pixel: dropped ones still count, the terminal one ends capture.
         if (capture_pix) begin
            px_count <= px_next;
            if (!push) begin
               overflow <= 1'b1;
            end
            if (last_pix) begin
               state <= S_DRAIN;
            end
         end
      end
   end

endmodule

// File: tb/tb_pixel_stream_capture.sv
// Bench for pixel_stream_capture at 4x2 frame, 4-deep FIFO, 4 channels.
// A queue-based frame model is compared against the DUT on every falling edge;
// directed tests add literal expectations on the drained stream and flags.
module tb_pixel_stream_capture;
   localparam int unsigned W     = 4;
   localparam int unsigned H     = 2;
   localparam int unsigned PW    = 8;
   localparam int unsigned NCH   = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TOTAL = W * H;
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);

   logic              clk_25MHz = 1'b0;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic [1:0]        ch_sel;
   logic              sof;
   logic [NCH*PW-1:0] pix_data;
   logic [NCH-1:0]    pix_valid;
   logic              busy, done, overflow, frame_err;
   logic [CNT_W-1:0]  px_count;
`ifdef CAPTURE_CHECKSUM_EN
   logic [31:0]       checksum;
`endif

   pixel_stream_capture_if #(.PIX_W(PW)) oif ();

   pixel_stream_capture #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_25MHz (clk_25MHz),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .ch_sel    (ch_sel),
      .sof       (sof),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .out_if    (oif),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .frame_err (frame_err),
      .px_count  (px_count)
`ifdef CAPTURE_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #20 clk_25MHz = ~clk_25MHz;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame model ----------------
   typedef enum {M_IDLE, M_ARMED, M_CAP, M_DRAIN, M_DONE} mph_t;
   mph_t        mph;
   logic [7:0]  m_q[$];
   int          m_sel;
   int          m_cnt;
   bit          m_ovf, m_ferr;
   logic [31:0] m_csum;

   always @(posedge clk_25MHz or negedge rst_n) begin
      int         sz0;
      bit         take;
      logic [7:0] px;
      if (!rst_n) begin
         mph = M_IDLE; m_q.delete(); m_sel = 0; m_cnt = 0;
         m_ovf = 0; m_ferr = 0; m_csum = '0;
      end else begin
         sz0  = m_q.size();
         take = 0;
         px   = pix_data[m_sel*PW +: PW];
         if (abort) begin
            m_q.delete();
            mph = M_IDLE;
         end else begin
            if (sz0 != 0 && oif.out_ready) void'(m_q.pop_front());
            case (mph)
               M_IDLE, M_DONE: if (start) begin
                  mph = M_ARMED; m_sel = int'(ch_sel); m_cnt = 0;
                  m_ovf = 0; m_ferr = 0; m_csum = '0; m_q.delete();
               end
               M_ARMED: if (sof) begin mph = M_CAP; take = pix_valid[m_sel]; end
               M_CAP: if (sof) begin m_ferr = 1; mph = M_DRAIN; end
                      else take = pix_valid[m_sel];
               M_DRAIN: if (sz0 == 0) mph = M_DONE;
               default: ;
            endcase
            if (take) begin
               m_cnt++;
               if (m_q.size() < DEPTH) begin
                  m_q.push_back(px);
                  m_csum = {m_csum[30:0], m_csum[31]} ^ {24'h0, px};
               end else begin
                  m_ovf = 1;
               end
               if (m_cnt == TOTAL) mph = M_DRAIN;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk_25MHz) begin
      if (rst_n) begin
         chk("out_valid", 32'(oif.out_valid), 32'(m_q.size() != 0));
         if (m_q.size() != 0) chk("out_data", 32'(oif.out_data), 32'(m_q[0]));
         chk("busy", 32'(busy), 32'(mph inside {M_ARMED, M_CAP, M_DRAIN}));
         chk("done", 32'(done), 32'(mph == M_DONE));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("frame_err", 32'(frame_err), 32'(m_ferr));
         chk("px_count", 32'(px_count), 32'(m_cnt));
`ifdef CAPTURE_CHECKSUM_EN
         chk("checksum", checksum, m_csum);
`endif
      end
   end

   // Record every word the consumer accepts.
   logic [7:0] got[$];
   always @(negedge clk_25MHz) begin
      if (rst_n && oif.out_valid && oif.out_ready) got.push_back(oif.out_data);
   end

   // ---------------- stimulus ----------------
   int lane = 2;

   task automatic step();
      @(posedge clk_25MHz);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; abort = 0; sof = 0;
      pix_data  = '1;
      pix_valid = 4'b1111;
      pix_valid[lane] = 1'b0;
   endtask

   task automatic drive_pix(input logic [7:0] v, input logic s);
      pix_data = '1;
      pix_data[lane*PW +: PW] = v;
      pix_valid = 4'b1111;
      sof = s;
      step();
      idle_inputs();
   endtask

   task automatic arm(input logic [1:0] ch);
      start = 1; ch_sel = ch;
      step();
      start = 0;
   endtask

   task automatic wait_done(input int budget);
      int i = 0;
      while (!done && i < budget) begin
         step();
         i++;
      end
      chk("done_reached", 32'(done), 32'd1);
   endtask

   task automatic check_stream(input logic [7:0] base, input int n);
      chk("stream_len", 32'(got.size()), 32'(n));
      for (int i = 0; i < n && i < got.size(); i++) begin
         logic [7:0] e;
         e = base + 8'(i);
         chk("stream_data", 32'(got[i]), 32'(e));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(oif.out_valid), 32'd0);
      chk({tag, "_out_data"}, 32'(oif.out_data), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
      chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      chk({tag, "_px_count"}, 32'(px_count), 32'd0);
   endtask

   initial begin
      rst_n = 0; ch_sel = 0; oif.out_ready = 1;
      idle_inputs();
      repeat (3) step();
      check_reset_outputs("reset");
      rst_n = 1;
      step();

      // Full frame on ch2, consumer always ready, with a wait cycle and a gap.
      got.delete(); lane = 2; oif.out_ready = 1;
      arm(2);
      chk("armed_busy", 32'(busy), 32'd1);
      step();
      drive_pix(8'h10, 1);
      for (int i = 1; i < 8; i++) begin
         if (i == 4) step();
         drive_pix(8'h10 + 8'(i), 0);
      end
      wait_done(40);
      check_stream(8'h10, 8);
      chk("t1_px_count", 32'(px_count), 32'd8);
      chk("t1_overflow", 32'(overflow), 32'd0);
      chk("t1_frame_err", 32'(frame_err), 32'd0);

      // Consumer stalled during capture: last four pixels dropped.
      got.delete(); oif.out_ready = 0;
      arm(2);
      drive_pix(8'h10, 1);
      for (int i = 1; i < 8; i++) drive_pix(8'h10 + 8'(i), 0);
      chk("t2_overflow", 32'(overflow), 32'd1);
      chk("t2_head", 32'(oif.out_data), 32'h10);
      oif.out_ready = 1;
      wait_done(40);
      check_stream(8'h10, 4);
      chk("t2_px_count", 32'(px_count), 32'd8);

      // Early sof after three pixels.
      got.delete(); oif.out_ready = 1;
      arm(2);
      drive_pix(8'h30, 1);
      drive_pix(8'h31, 0);
      drive_pix(8'h32, 0);
      drive_pix(8'h33, 1);
      wait_done(40);
      check_stream(8'h30, 3);
      chk("t3_frame_err", 32'(frame_err), 32'd1);
      chk("t3_px_count", 32'(px_count), 32'd3);

      // Fill the FIFO, then push and pop together while full.
      got.delete(); oif.out_ready = 0;
      arm(2);
      drive_pix(8'h20, 1);
      for (int i = 1; i < 4; i++) drive_pix(8'h20 + 8'(i), 0);
      chk("t4_full_head", 32'(oif.out_data), 32'h20);
      oif.out_ready = 1;
      for (int i = 4; i < 8; i++) drive_pix(8'h20 + 8'(i), 0);
      wait_done(40);
      check_stream(8'h20, 8);
      chk("t4_overflow", 32'(overflow), 32'd0);

      // Abort mid-capture on ch1 with two entries queued.
      got.delete(); lane = 1; oif.out_ready = 0;
      idle_inputs();
      arm(1);
      drive_pix(8'h40, 1);
      drive_pix(8'h41, 0);
      chk("t5_valid_before", 32'(oif.out_valid), 32'd1);
      abort = 1;
      step();
      abort = 0;
      chk("t5_out_valid", 32'(oif.out_valid), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_px_kept", 32'(px_count), 32'd2);
      step();

      // Reset asserted mid-drain.
      lane = 2; idle_inputs(); oif.out_ready = 0;
      arm(2);
      drive_pix(8'h50, 1);
      for (int i = 1; i < 8; i++) drive_pix(8'h50 + 8'(i), 0);
      chk("t6_busy_drain", 32'(busy), 32'd1);
      #5;
      rst_n = 0;
      #1;
      check_reset_outputs("midreset");
      step(); step();
      rst_n = 1;
      oif.out_ready = 1;
      step();

`ifdef CAPTURE_CHECKSUM_EN
      arm(2);
      drive_pix(8'h01, 1);
      drive_pix(8'h02, 0);
      drive_pix(8'h00, 1);
      wait_done(40);
      chk("csum_01_02", checksum, 32'h0000_0000);
      arm(2);
      drive_pix(8'h01, 1);
      drive_pix(8'h03, 0);
      drive_pix(8'h00, 1);
      wait_done(40);
      chk("csum_01_03", checksum, 32'h0000_0001);
`endif

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
